alu_result_packer: RTL and testbench
====================================

# alu_result_packer

Serialises each registered ALU result into bytes for the byte-wide TX FIFO write port. It sits between the ALU output register and the FIFO write side, and splits one `RESULT_WIDTH` result into two FIFO writes. It honours FIFO backpressure and flags results that arrive while it cannot take them.

## Interface
Parameters:
- `BYTE_WIDTH`, default 8: FIFO word width, equal to the ALU operand width.
- `RESULT_WIDTH`, localparam = 2*`BYTE_WIDTH`: ALU result width.
- `MSB_FIRST`, default 0: 0 sends the low byte first; 1 sends the high byte first.

Ports (one clock; reset is synchronous and active-high):
- `CLK`  in  1: sole clock; all state updates on the rising edge.
- `RST`  in  1: synchronous, active-high reset.
- `ALU_OUT`  in  `RESULT_WIDTH`: ALU result.
- `ALU_OUT_VALID`  in  1: single-cycle strobe qualifying `ALU_OUT`.
- `FIFO_FULL`  in  1: FIFO cannot accept a write this cycle.
- `OVR_CLR`  in  1: clears `OVERRUN`.
- `WR_DATA`  out  `BYTE_WIDTH`: byte presented to the FIFO.
- `WR_INC`  out  1: FIFO write strobe; a write occurs on every edge where it is 1.
- `BUSY`  out  1: high when state is not IDLE.
- `OVERRUN`  out  1: sticky flag; a result was dropped.

## Operation
- State machine with three states: IDLE, SEND_FIRST, SEND_SECOND. `hold` is a `RESULT_WIDTH` register.
- First byte = `hold[BYTE_WIDTH-1:0]` when `MSB_FIRST`=0, else the high byte. Second byte is the other half.
- `WR_INC` = (state is SEND_FIRST or SEND_SECOND) AND NOT `FIFO_FULL`. This is combinational from registered state and the `FIFO_FULL` input.
- `WR_DATA` = byte for the current state when `WR_INC`=1, otherwise 0.
- IDLE:
  - `ALU_OUT_VALID`=1: `hold` <= `ALU_OUT`; next state SEND_FIRST.
  - Otherwise stay in IDLE.
- SEND_FIRST:
  - `WR_INC`=1: next state SEND_SECOND.
  - Otherwise hold state; stall indefinitely while `FIFO_FULL`=1.
- SEND_SECOND:
  - `WR_INC`=1 and `ALU_OUT_VALID`=1: `hold` <= `ALU_OUT`; next state SEND_FIRST. This is back-to-back acceptance.
  - `WR_INC`=1 and no valid: next state IDLE.
  - Otherwise hold state.
- Overrun:
  - Condition: `ALU_OUT_VALID`=1 in SEND_FIRST, or in SEND_SECOND with `WR_INC`=0.
  - The new result is discarded; `hold` is unchanged; `OVERRUN` <= 1.
  - If overrun and `OVR_CLR` occur in the same cycle, set wins.
- `OVR_CLR`=1 with no overrun that cycle: `OVERRUN` <= 0.
- `BUSY` = (state != IDLE). It is advisory only; upstream must pace issue to at most one result per 2 cycles to avoid overrun.
- No arithmetic on data; bytes are pure slices of `hold`, with no sign or width conversion.

## Timing
- Reset: when `RST`=1 at an edge, state <= IDLE, `hold` <= 0, `OVERRUN` <= 0. In the following cycle `BUSY`=0, `WR_INC`=0, `WR_DATA`=0.
- Reset mid-operation: any pending or partially sent result is discarded with no further writes. `RST` has priority over all other inputs, including `ALU_OUT_VALID`.
- Latency with the FIFO never full: valid sampled at edge k gives the first byte written at edge k+1 and the second byte at edge k+2. Return to IDLE after edge k+2, or SEND_FIRST if a new valid arrived in that same cycle.
- Throughput: one result per 2 cycles, sustained.
- `FIFO_FULL` is sampled every cycle with no registering; each cycle of full adds exactly one cycle of stall to the current byte.
- Byte order within a result is never interleaved with another result.

## Test plan
- Reset, then `ALU_OUT`=0x1234 valid for 1 cycle with FIFO never full -> `WR_INC` high for 2 consecutive cycles with `WR_DATA` 0x34 then 0x12. `BUSY` falls after the second write. `OVERRUN`=0.
- `MSB_FIRST`=1 with 0xABCD -> writes 0xAB then 0xCD.
- 0x00FF accepted, `FIFO_FULL`=1 for 3 cycles starting in SEND_FIRST -> `WR_INC`=0 and `WR_DATA`=0 for those 3 cycles. Then writes 0xFF, then 0x00. Exactly 2 writes total.
- Valid every 2nd cycle with 0x0102, 0x0304, 0x0506 -> writes 02,01,04,03,06,05 on 6 consecutive edges. `OVERRUN` stays 0.
- Valids on two consecutive cycles (0x1111 then 0x2222) -> only 11,11 written. `OVERRUN`=1 from the cycle after the second valid. `OVR_CLR` pulse returns it to 0. `OVR_CLR` coincident with a new overrun leaves it at 1.
- 0x5A5A accepted, `RST`=1 for 1 cycle immediately after the first write -> no second write. Outputs are 0 and `BUSY`=0 after the reset edge. The next result 0x0F0E is sent normally as 0E,0F.

Source files
------------

// File: rtl/alu_result_packer.sv
// alu_result_packer
//   Serialises one registered ALU result (two bytes wide) into two
//   consecutive writes on a byte-wide TX FIFO write port. It honours FIFO
//   backpressure and raises a sticky flag when a result arrives while it
//   cannot be taken.
//
// Ports
//   CLK            sole clock, rising edge
//   RST            synchronous, active-high reset
//   ALU_OUT        result to serialise (RESULT_WIDTH)
//   ALU_OUT_VALID  single-cycle strobe qualifying ALU_OUT
//   FIFO_FULL      FIFO cannot accept a write this cycle
//   OVR_CLR        clears OVERRUN (a coincident new overrun wins)
//   WR_DATA        byte presented to the FIFO, 0 when not writing
//   WR_INC         FIFO write strobe
//   BUSY           a result is still being sent
//   OVERRUN        sticky: a result was dropped
module alu_result_packer #(
    parameter int  BYTE_WIDTH   = 8,
    parameter bit  MSB_FIRST    = 1'b0,
    localparam int RESULT_WIDTH = 2 * BYTE_WIDTH
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [RESULT_WIDTH-1:0] ALU_OUT,
    input  logic                    ALU_OUT_VALID,
    input  logic                    FIFO_FULL,
    input  logic                    OVR_CLR,
    output logic [BYTE_WIDTH-1:0]   WR_DATA,
    output logic                    WR_INC,
    output logic                    BUSY,
    output logic                    OVERRUN
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FIRST  = 2'd1,
        S_SECOND = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [RESULT_WIDTH-1:0] hold_q, hold_d;
    logic                    ovr_q, ovr_d;
    logic                    ovr_set;

    logic [BYTE_WIDTH-1:0]   byte_lo, byte_hi;
    logic [BYTE_WIDTH-1:0]   byte_first, byte_second;
    logic                    sending;
    logic                    wr_inc;

    assign byte_lo     = hold_q[BYTE_WIDTH-1:0];
    assign byte_hi     = hold_q[RESULT_WIDTH-1:BYTE_WIDTH];
    assign byte_first  = MSB_FIRST ? byte_hi : byte_lo;
    assign byte_second = MSB_FIRST ? byte_lo : byte_hi;

    assign sending = (state_q == S_FIRST) || (state_q == S_SECOND);

    // Reset is gated in so that the edge that discards a partially sent
    // result does not also push its second byte into the FIFO.
    assign wr_inc  = sending && !FIFO_FULL && !RST;

    assign WR_INC  = wr_inc;
    assign WR_DATA = !wr_inc              ? '0 :
                     (state_q == S_FIRST) ? byte_first : byte_second;
    assign BUSY    = (state_q != S_IDLE);
    assign OVERRUN = ovr_q;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        ovr_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ALU_OUT_VALID) begin
                    hold_d  = ALU_OUT;
                    state_d = S_FIRST;
                end
            end
            S_FIRST: begin
                // Second byte still pending: nothing can be accepted here.
                if (ALU_OUT_VALID) ovr_set = 1'b1;
                if (wr_inc)        state_d = S_SECOND;
            end
            S_SECOND: begin
                if (wr_inc) begin
                    if (ALU_OUT_VALID) begin
                        // Last byte leaves this edge, so the register frees up
                        // in time to take a back-to-back result.
                        hold_d  = ALU_OUT;
                        state_d = S_FIRST;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (ALU_OUT_VALID) begin
                    ovr_set = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        ovr_d = ovr_q;
        if (ovr_set)      ovr_d = 1'b1;
        else if (OVR_CLR) ovr_d = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            hold_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            ovr_q   <= ovr_d;
        end
    end

endmodule

// File: tb/tb_alu_result_packer.sv
module tb_alu_result_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] alu = '0;
    logic        valid = 1'b0;
    logic        full = 1'b0;
    logic        clr = 1'b0;

    logic [7:0]  data_l, data_m;
    logic        inc_l, inc_m, busy_l, busy_m, ovr_l, ovr_m;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_result_packer #(.BYTE_WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .CLK(clk), .RST(rst), .ALU_OUT(alu), .ALU_OUT_VALID(valid),
        .FIFO_FULL(full), .OVR_CLR(clr),
        .WR_DATA(data_l), .WR_INC(inc_l), .BUSY(busy_l), .OVERRUN(ovr_l)
    );

    alu_result_packer #(.BYTE_WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .CLK(clk), .RST(rst), .ALU_OUT(alu), .ALU_OUT_VALID(valid),
        .FIFO_FULL(full), .OVR_CLR(clr),
        .WR_DATA(data_m), .WR_INC(inc_m), .BUSY(busy_m), .OVERRUN(ovr_m)
    );

    // One record per cycle: inputs for the cycle and the outputs expected
    // while those inputs are applied (before the next rising edge).
    typedef struct {
        logic        rst, valid;
        logic [15:0] alu;
        logic        full, clr, chk;
        logic        inc;
        logic [7:0]  d_lsb, d_msb;
        logic        busy, ovr;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic v, input logic [15:0] a,
                       input logic f, input logic c, input logic k,
                       input logic i, input logic [7:0] dl, input logic [7:0] dm,
                       input logic b, input logic o);
        vec_t e;
        e.rst = r; e.valid = v; e.alu = a; e.full = f; e.clr = c; e.chk = k;
        e.inc = i; e.d_lsb = dl; e.d_msb = dm; e.busy = b; e.ovr = o;
        tbl.push_back(e);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ei, input logic [7:0] edl,
                             input logic [7:0] edm, input logic eb, input logic eo);
        check({tag, ".inc_lsb"},  {15'd0, inc_l},  {15'd0, ei});
        check({tag, ".inc_msb"},  {15'd0, inc_m},  {15'd0, ei});
        check({tag, ".data_lsb"}, {8'd0, data_l},  {8'd0, edl});
        check({tag, ".data_msb"}, {8'd0, data_m},  {8'd0, edm});
        check({tag, ".busy"},     {14'd0, busy_l, busy_m}, {14'd0, eb, eb});
        check({tag, ".ovr"},      {14'd0, ovr_l, ovr_m},   {14'd0, eo, eo});
    endtask

    // Reference model: a queue of bytes still owed to the FIFO per byte order.
    logic [7:0] q_l[$];
    logic [7:0] q_m[$];
    logic       m_ovr;

    initial begin
        //   rst v  alu      f  c  chk inc dl     dm     busy ovr
        add(1, 0, 16'h0000, 0, 0, 0,  0, 8'h00, 8'h00, 0, 0);
        // basic 0x1234 / 0xABCD, both byte orders
        add(0, 0, 16'h0000, 0, 0, 1,  0, 8'h00, 8'h00, 0, 0);
        add(0, 1, 16'h1234, 0, 0, 1,  0, 8'h00, 8'h00, 0, 0);
        add(0, 0, 16'h0000, 0, 0, 1,  1, 8'h34, 8'h12, 1, 0);
        add(0, 0, 16'h0000, 0, 0, 1,  1, 8'h12, 8'h34, 1, 0);
        add(0, 0, 16'h0000, 0, 0, 1,  0, 8'h00, 8'h00, 0, 0);
        add(0, 1, 16'hABCD, 0, 0, 1,  0, 8'h00, 8'h00, 0, 0);
        add(0, 0, 16'h0000, 0, 0, 1,  1, 8'hCD, 8'hAB, 1, 0);
        add(0, 0, 16'h0000, 0, 0, 1,  1, 8'hAB, 8'hCD, 1, 0);
        add(0, 0, 16'h0000, 0, 0, 1,  0, 8'h00, 8'h00, 0, 0);
        // 0x00FF with three cycles of FIFO full in the first byte
        add(0, 1, 16'h00FF, 0, 0, 1,  0, 8'h00, 8'h00, 0, 0);
        add(0, 0, 16'h0000, 1, 0, 1,  0, 8'h00, 8'h00, 1, 0);
        add(0, 0, 16'h0000, 1, 0, 1,  0, 8'h00, 8'h00, 1, 0);
        add(0, 0, 16'h0000, 1, 0, 1,  0, 8'h00, 8'h00, 1, 0);
        add(0, 0, 16'h0000, 0, 0, 1,  1, 8'hFF, 8'h00, 1, 0);
        add(0, 0, 16'h0000, 0, 0, 1,  1, 8'h00, 8'hFF, 1, 0);
        add(0, 0, 16'h0000, 0, 0, 1,  0, 8'h00, 8'h00, 0, 0);
        // sustained one result every two cycles
        add(0, 1, 16'h0102, 0, 0, 1,  0, 8'h00, 8'h00, 0, 0);
        add(0, 0, 16'h0000, 0, 0, 1,  1, 8'h02, 8'h01, 1, 0);
        add(0, 1, 16'h0304, 0, 0, 1,  1, 8'h01, 8'h02, 1, 0);
        add(0, 0, 16'h0000, 0, 0, 1,  1, 8'h04, 8'h03, 1, 0);
        add(0, 1, 16'h0506, 0, 0, 1,  1, 8'h03, 8'h04, 1, 0);
        add(0, 0, 16'h0000, 0, 0, 1,  1, 8'h06, 8'h05, 1, 0);
        add(0, 0, 16'h0000, 0, 0, 1,  1, 8'h05, 8'h06, 1, 0);
        add(0, 0, 16'h0000, 0, 0, 1,  0, 8'h00, 8'h00, 0, 0);
        // back-to-back valids -> overrun, clear, then set-wins-over-clear
        add(0, 1, 16'h1111, 0, 0, 1,  0, 8'h00, 8'h00, 0, 0);
        add(0, 1, 16'h2222, 0, 0, 1,  1, 8'h11, 8'h11, 1, 0);
        add(0, 0, 16'h0000, 0, 0, 1,  1, 8'h11, 8'h11, 1, 1);
        add(0, 0, 16'h0000, 0, 1, 1,  0, 8'h00, 8'h00, 0, 1);
        add(0, 0, 16'h0000, 0, 0, 1,  0, 8'h00, 8'h00, 0, 0);
        add(0, 1, 16'h3333, 0, 0, 1,  0, 8'h00, 8'h00, 0, 0);
        add(0, 1, 16'h4444, 0, 0, 1,  1, 8'h33, 8'h33, 1, 0);
        add(0, 1, 16'h5555, 1, 1, 1,  0, 8'h00, 8'h00, 1, 1);
        add(0, 0, 16'h0000, 0, 0, 1,  1, 8'h33, 8'h33, 1, 1);
        add(0, 0, 16'h0000, 0, 1, 1,  0, 8'h00, 8'h00, 0, 1);
        add(0, 0, 16'h0000, 0, 0, 1,  0, 8'h00, 8'h00, 0, 0);
        // reset right after the first byte of 0x5A5A, then 0x0F0E
        add(0, 1, 16'h5A5A, 0, 0, 1,  0, 8'h00, 8'h00, 0, 0);
        add(0, 0, 16'h0000, 0, 0, 1,  1, 8'h5A, 8'h5A, 1, 0);
        add(1, 1, 16'h7777, 0, 0, 1,  0, 8'h00, 8'h00, 1, 0);
        add(0, 0, 16'h0000, 0, 0, 1,  0, 8'h00, 8'h00, 0, 0);
        add(0, 1, 16'h0F0E, 0, 0, 1,  0, 8'h00, 8'h00, 0, 0);
        add(0, 0, 16'h0000, 0, 0, 1,  1, 8'h0E, 8'h0F, 1, 0);
        add(0, 0, 16'h0000, 0, 0, 1,  1, 8'h0F, 8'h0E, 1, 0);
        add(0, 0, 16'h0000, 0, 0, 1,  0, 8'h00, 8'h00, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst = tbl[i].rst; valid = tbl[i].valid; alu = tbl[i].alu;
            full = tbl[i].full; clr = tbl[i].clr;
            #1;
            if (tbl[i].chk)
                check_all($sformatf("vec%0d", i), tbl[i].inc, tbl[i].d_lsb,
                          tbl[i].d_msb, tbl[i].busy, tbl[i].ovr);
        end

        // Randomised phase against the queue model; begins with a reset.
        q_l.delete(); q_m.delete(); m_ovr = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            logic       e_inc, e_busy, accept;
            logic [7:0] e_dl, e_dm;
            @(negedge clk);
            rst   = (c == 0) || ($urandom_range(0, 99) < 2);
            valid = ($urandom_range(0, 99) < 45);
            alu   = 16'($urandom);
            full  = ($urandom_range(0, 99) < 30);
            clr   = ($urandom_range(0, 99) < 10);
            #1;
            e_busy = (q_l.size() != 0);
            e_inc  = !rst && (q_l.size() != 0) && !full;
            e_dl   = e_inc ? q_l[0] : 8'h00;
            e_dm   = e_inc ? q_m[0] : 8'h00;
            if (c > 0) check_all($sformatf("rnd%0d", c), e_inc, e_dl, e_dm, e_busy, m_ovr);

            if (rst) begin
                q_l.delete(); q_m.delete(); m_ovr = 1'b0;
            end else begin
                // Room exists if nothing is owed, or the last owed byte
                // leaves this very cycle.
                accept = valid && ((q_l.size() == 0) || (q_l.size() == 1 && e_inc));
                if (e_inc) begin
                    void'(q_l.pop_front());
                    void'(q_m.pop_front());
                end
                if (accept) begin
                    q_l.push_back(alu[7:0]);  q_l.push_back(alu[15:8]);
                    q_m.push_back(alu[15:8]); q_m.push_back(alu[7:0]);
                end
                if (valid && !accept) m_ovr = 1'b1;
                else if (clr)         m_ovr = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
